// File: rtl/simd4_lane_packer.sv
// Packs a stream of scalar (a,b) operand pairs into LANES-wide words, lane 0 in the MS slice.
// Optional partial-word flush is enabled by defining SIMD4_PACK_FLUSH_EN.
module simd4_lane_packer #(
  parameter int LANE_W = 12,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W-1:0]         in_a,
  input  logic [LANE_W-1:0]         in_b,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_a,
  output logic [LANES*LANE_W-1:0]   out_b,
  output logic [LANES-1:0]          out_mask,
  output logic [1:0]                dbg_lane_cnt
);

  localparam int W = LANES * LANE_W;

  typedef enum logic [1:0] {LANE_0, LANE_1, LANE_2, LANE_3} lane_t;

  lane_t            lane_cnt, lane_cnt_n;
  logic [W-1:0]     acc_a, acc_b, acc_a_n, acc_b_n;
  logic [W-1:0]     ins_a, ins_b, out_a_n, out_b_n;
  logic [LANES-1:0] out_mask_n, fill_mask;
  logic             out_valid_n, slot_free, accept, load;
  logic [2:0]       fill;

  // Handshake: a transfer happens on a side only in a cycle where valid and
  // ready are both high with ce=1; valid never waits on ready.
  always_comb begin
    slot_free = ~out_valid | out_ready;
`ifdef SIMD4_PACK_FLUSH_EN
    in_ready = ce & (flush ? slot_free : ((lane_cnt != LANE_3) | slot_free));
`else
    in_ready = ce & ((lane_cnt != LANE_3) | slot_free);
`endif
    accept = in_valid & in_ready;

    // Accumulator with the incoming pair dropped into its lane
    ins_a = acc_a;
    ins_b = acc_b;
    for (int k = 0; k < LANES; k++) begin
      if (accept && (int'(lane_cnt) == k)) begin
        ins_a[(LANES-k)*LANE_W-1 -: LANE_W] = in_a;
        ins_b[(LANES-k)*LANE_W-1 -: LANE_W] = in_b;
      end
    end

    fill      = {1'b0, lane_cnt} + {2'b00, accept};
    fill_mask = ~({LANES{1'b1}} >> fill);

`ifdef SIMD4_PACK_FLUSH_EN
    load = (accept & (lane_cnt == LANE_3)) |
           (ce & flush & slot_free & (fill != 3'd0));
`else
    load = accept & (lane_cnt == LANE_3);
`endif

    lane_cnt_n  = lane_cnt;
    acc_a_n     = acc_a;
    acc_b_n     = acc_b;
    out_a_n     = out_a;
    out_b_n     = out_b;
    out_mask_n  = out_mask;
    out_valid_n = out_valid;

    if (load) begin
      out_a_n     = ins_a;
      out_b_n     = ins_b;
      out_mask_n  = fill_mask;
      out_valid_n = 1'b1;
      lane_cnt_n  = LANE_0;
      acc_a_n     = '0;
      acc_b_n     = '0;
    end else begin
      if (accept) begin
        acc_a_n    = ins_a;
        acc_b_n    = ins_b;
        lane_cnt_n = lane_t'(lane_cnt + 2'd1);
      end
      if (ce & out_valid & out_ready) out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt  <= LANE_0;
      acc_a     <= '0;
      acc_b     <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_mask  <= '0;
      out_valid <= 1'b0;
    end else begin
      lane_cnt  <= lane_cnt_n;
      acc_a     <= acc_a_n;
      acc_b     <= acc_b_n;
      out_a     <= out_a_n;
      out_b     <= out_b_n;
      out_mask  <= out_mask_n;
      out_valid <= out_valid_n;
    end
  end

  assign dbg_lane_cnt = lane_cnt;

`ifndef SIMD4_PACK_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_simd4_lane_packer.sv
// Bench for simd4_lane_packer: directed cases with literal expectations, then random traffic
// checked every cycle against a queue-based model of the packing rules.
module tb_simd4_lane_packer;
  localparam int LW = 12;
  localparam int NL = 4;
`ifdef SIMD4_PACK_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, in_ready, flush, out_valid, out_ready;
  logic [11:0] in_a, in_b;
  logic [47:0] out_a, out_b;
  logic [3:0]  out_mask;
  logic [1:0]  dbg_lane_cnt;

  simd4_lane_packer #(.LANE_W(LW), .LANES(NL)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_mask(out_mask),
    .dbg_lane_cnt(dbg_lane_cnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  // model: partial word as a queue of lanes plus the held output word
  logic [11:0] pa[$];
  logic [11:0] pb[$];
  logic        m_valid;
  logic [47:0] m_a, m_b;
  logic [3:0]  m_mask;
  logic [95:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pa.delete();
    pb.delete();
    m_valid = 1'b0;
    m_a = '0;
    m_b = '0;
    m_mask = '0;
    exp_q.delete();
  endtask

  // driver + per-cycle compare; the model then advances across the coming edge
  task automatic cycle(input bit c, input bit v, input logic [11:0] a, input logic [11:0] b,
                       input bit r, input bit f, output bit rdy);
    bit          slot_free, exp_rdy, acc, emit;
    logic [47:0] wa, wb;
    logic [3:0]  wm;
    logic [95:0] w;
    @(negedge clk);
    ce = c; in_valid = v; in_a = a; in_b = b; out_ready = r; flush = f;
    #1;
    chk("out_valid", 48'(out_valid), 48'(m_valid));
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_mask", 48'(out_mask), 48'(m_mask));
    chk("lane_cnt", 48'(dbg_lane_cnt), 48'(pa.size()));
    slot_free = !m_valid || r;
    if (!c) exp_rdy = 1'b0;
    else if (FLUSH_EN && f) exp_rdy = slot_free;
    else exp_rdy = (pa.size() < 3) || slot_free;
    chk("in_ready", 48'(in_ready), 48'(exp_rdy));
    rdy = in_ready;
    if (out_valid && out_ready && ce) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_empty actual=word_taken required=no_word at %0t", $time);
      end else begin
        w = exp_q.pop_front();
        chk("drain_a", out_a, w[95:48]);
        chk("drain_b", out_b, w[47:0]);
      end
    end
    if (c) begin
      acc = v && exp_rdy;
      if (acc) begin
        pa.push_back(a);
        pb.push_back(b);
      end
      emit = (pa.size() == NL) || (FLUSH_EN && f && slot_free && pa.size() > 0);
      if (emit) begin
        wa = '0; wb = '0; wm = '0;
        foreach (pa[k]) begin
          wa = wa | (48'(pa[k]) << ((NL - 1 - k) * LW));
          wb = wb | (48'(pb[k]) << ((NL - 1 - k) * LW));
          wm = wm | (4'b1000 >> k);
        end
        m_a = wa; m_b = wb; m_mask = wm; m_valid = 1'b1;
        exp_q.push_back({wa, wb});
        pa.delete();
        pb.delete();
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rdy;
    rst = 1'b0; ce = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 48'(out_valid), 48'h0);
    chk("rst_out_a", out_a, 48'h0);
    chk("rst_out_b", out_b, 48'h0);
    chk("rst_out_mask", 48'(out_mask), 48'h0);
    chk("rst_lane_cnt", 48'(dbg_lane_cnt), 48'h0);
    rst = 1'b1;

    // reset while a word is held and two lanes are accumulated
    for (int i = 0; i < 6; i++) cycle(1, 1, 12'(i + 5), 12'(i + 9), 0, 0, rdy);
    settle();
    chk("pre_rst_lane_cnt", 48'(dbg_lane_cnt), 48'h2);
    chk("pre_rst_valid", 48'(out_valid), 48'h1);
    @(negedge clk);
    ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", 48'(out_valid), 48'h0);
    chk("arst_out_a", out_a, 48'h0);
    chk("arst_lane_cnt", 48'(dbg_lane_cnt), 48'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // basic stream, lane 0 in the MS slice
    cycle(1, 1, 12'h001, 12'hFFF, 1, 0, rdy);
    cycle(1, 1, 12'h002, 12'h800, 1, 0, rdy);
    cycle(1, 1, 12'h003, 12'h7FF, 1, 0, rdy);
    cycle(1, 1, 12'h004, 12'h001, 1, 0, rdy);
    settle();
    chk("t2_valid", 48'(out_valid), 48'h1);
    chk("t2_out_a", out_a, 48'h001002003004);
    chk("t2_out_b", out_b, 48'hFFF8007FF001);
    chk("t2_mask", 48'(out_mask), 48'hF);

    // backpressure: three lanes accepted, fourth stalls, then swaps in
    cycle(1, 1, 12'h010, 12'h0F1, 0, 0, rdy); chk("t3_rdy0", 48'(rdy), 48'h1);
    cycle(1, 1, 12'h020, 12'h0F2, 0, 0, rdy); chk("t3_rdy1", 48'(rdy), 48'h1);
    cycle(1, 1, 12'h030, 12'h0F3, 0, 0, rdy); chk("t3_rdy2", 48'(rdy), 48'h1);
    cycle(1, 1, 12'h040, 12'h0F4, 0, 0, rdy); chk("t3_stall", 48'(rdy), 48'h0);
    settle();
    chk("t3_held_a", out_a, 48'h001002003004);
    chk("t3_lane_cnt", 48'(dbg_lane_cnt), 48'h3);
    cycle(1, 1, 12'h040, 12'h0F4, 1, 0, rdy); chk("t3_swap_rdy", 48'(rdy), 48'h1);
    settle();
    chk("t3_swap_valid", 48'(out_valid), 48'h1);
    chk("t3_swap_a", out_a, 48'h010020030040);
    chk("t3_swap_b", out_b, 48'h0F10F20F30F4);
    cycle(1, 0, 12'h0, 12'h0, 1, 0, rdy);

    // back-to-back: 8 pairs, two words, never stalls
    hs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1, 0, rdy);
      chk("t4_ready", 48'(rdy), 48'h1);
    end
    cycle(1, 0, 12'h0, 12'h0, 1, 0, rdy);
    chk("t4_words", 48'(hs_cnt), 48'h2);

    // clock enable low mid-word
    cycle(1, 1, 12'hAAA, 12'h000, 1, 0, rdy);
    cycle(1, 1, 12'h555, 12'h000, 1, 0, rdy);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 12'h777, 12'h000, 1, 0, rdy);
      chk("t5_ce_rdy", 48'(rdy), 48'h0);
    end
    settle();
    chk("t5_lane_cnt", 48'(dbg_lane_cnt), 48'h2);
    chk("t5_valid", 48'(out_valid), 48'h0);
    cycle(1, 1, 12'h123, 12'h000, 1, 0, rdy);
    cycle(1, 1, 12'h321, 12'h000, 1, 0, rdy);
    settle();
    chk("t5_out_a", out_a, 48'hAAA555123321);
    cycle(1, 0, 12'h0, 12'h0, 1, 0, rdy);

    // partial word flush
    cycle(1, 1, 12'h123, 12'h000, 1, 0, rdy);
    cycle(1, 1, 12'h456, 12'h000, 1, 0, rdy);
    cycle(1, 0, 12'h000, 12'h000, 1, 1, rdy);
    settle();
`ifdef SIMD4_PACK_FLUSH_EN
    chk("t6_valid", 48'(out_valid), 48'h1);
    chk("t6_out_a", out_a, 48'h123456000000);
    chk("t6_mask", 48'(out_mask), 48'hC);
`else
    chk("t6_valid", 48'(out_valid), 48'h0);
    chk("t6_lane_cnt", 48'(dbg_lane_cnt), 48'h2);
`endif
    cycle(1, 0, 12'h0, 12'h0, 1, 0, rdy);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
